// File: rtl/mac_accumulator_pkg.sv
// Shared constants, FSM state type and saturation helper for the MAC datapath.
package mac_accumulator_pkg;

  localparam int IN_W  = 16;
  localparam int ACC_W = 24;
  localparam int OUT_W = 8;
  localparam int CNT_W = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Clamp a signed value to the range of a signed field 'width' bits wide (width <= 32).
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/mac_accumulator_requant_sat.sv
// Requantiser: round-half-up arithmetic right shift of the accumulator, saturated to OUT_W.
module mac_accumulator_requant_sat #(
  parameter int ACC_W = mac_accumulator_pkg::ACC_W,
  parameter int OUT_W = mac_accumulator_pkg::OUT_W
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic        [3:0]       shift_i,
  output logic signed [OUT_W-1:0] data_o
);
  import mac_accumulator_pkg::*;

  logic signed [ACC_W:0] wide;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] shifted;

  // One extra bit of headroom so adding the rounding constant cannot wrap.
  always_comb begin
    wide    = {acc_i[ACC_W-1], acc_i};
    rnd     = (ACC_W+1)'(1) << (shift_i - 4'd1);
    shifted = (shift_i == 4'd0) ? wide : ((wide + rnd) >>> shift_i);
    data_o  = OUT_W'(sat_signed(32'(shifted), OUT_W));
  end

endmodule

// File: rtl/mac_accumulator.sv
// Group accumulator for the MAC product stream: saturating sum, beat count, requantised result.
//   state | meaning
//   ACCUM | accepting product beats, building the group sum
//   HOLD  | group result presented on io_out_*, waiting for io_out_ready
module mac_accumulator #(
  parameter int IN_W  = mac_accumulator_pkg::IN_W,
  parameter int ACC_W = mac_accumulator_pkg::ACC_W,
  parameter int OUT_W = mac_accumulator_pkg::OUT_W,
  parameter int CNT_W = mac_accumulator_pkg::CNT_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_in_valid,
  output logic                    io_in_ready,
  input  logic signed [IN_W-1:0]  io_in_data,
  input  logic                    io_in_last,
  input  logic        [3:0]       io_cfg_shift,
  output logic                    io_out_valid,
  input  logic                    io_out_ready,
  output logic signed [OUT_W-1:0] io_out_data,
  output logic signed [ACC_W-1:0] io_out_acc,
  output logic        [CNT_W-1:0] io_out_count,
  output logic                    io_out_overflow
);
  import mac_accumulator_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic                    first_q, first_d;
  logic                    ovf_q, ovf_d;
  logic        [3:0]       shift_q, shift_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic signed [ACC_W-1:0] out_acc_q, out_acc_d;
  logic        [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic                    out_ovf_q, out_ovf_d;

  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W:0]   sum;
  logic                    sum_sat;
  logic signed [ACC_W-1:0] acc_new;
  logic        [3:0]       shift_new;
  logic signed [OUT_W-1:0] rq_data;

  // A 24+16 bit signed add fits in ACC_W+1 bits, so a sign-bit mismatch is the overflow flag.
  assign base      = first_q ? '0 : acc_q;
  assign sum       = {base[ACC_W-1], base} + {{(ACC_W+1-IN_W){io_in_data[IN_W-1]}}, io_in_data};
  assign sum_sat   = sum[ACC_W] != sum[ACC_W-1];
  assign acc_new   = ACC_W'(sat_signed(32'(sum), ACC_W));
  assign shift_new = first_q ? io_cfg_shift : shift_q;

  mac_accumulator_requant_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_requant_sat (
    .acc_i  (acc_new),
    .shift_i(shift_new),
    .data_o (rq_data)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    ovf_d      = ovf_q;
    shift_d    = shift_q;
    out_data_d = out_data_q;
    out_acc_d  = out_acc_q;
    out_cnt_d  = out_cnt_q;
    out_ovf_d  = out_ovf_q;
    case (state_q)
      ACCUM: begin
        if (io_in_valid) begin
          acc_d   = acc_new;
          shift_d = shift_new;
          cnt_d   = first_q ? CNT_W'(1) : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1));
          ovf_d   = (first_q ? 1'b0 : ovf_q) | sum_sat;
          first_d = 1'b0;
          if (io_in_last) begin
            out_data_d = rq_data;
            out_acc_d  = acc_new;
            out_cnt_d  = cnt_d;
            out_ovf_d  = ovf_d;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (io_out_ready) begin
          state_d = ACCUM;
          first_d = 1'b1;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b1;
      ovf_q      <= 1'b0;
      shift_q    <= '0;
      out_data_q <= '0;
      out_acc_q  <= '0;
      out_cnt_q  <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      ovf_q      <= ovf_d;
      shift_q    <= shift_d;
      out_data_q <= out_data_d;
      out_acc_q  <= out_acc_d;
      out_cnt_q  <= out_cnt_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign io_in_ready     = (state_q == ACCUM);
  assign io_out_valid    = (state_q == HOLD);
  assign io_out_data     = out_data_q;
  assign io_out_acc      = out_acc_q;
  assign io_out_count    = out_cnt_q;
  assign io_out_overflow = out_ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: reference model pushes group results, DUT outputs pop them.
module tb_mac_accumulator;

  localparam longint ACC_MAX = 64'sd8388607;
  localparam longint ACC_MIN = -64'sd8388608;

  logic               clock = 1'b0;
  logic               reset;
  logic               io_in_valid;
  logic               io_in_ready;
  logic signed [15:0] io_in_data;
  logic               io_in_last;
  logic        [3:0]  io_cfg_shift;
  logic               io_out_valid;
  logic               io_out_ready;
  logic signed [7:0]  io_out_data;
  logic signed [23:0] io_out_acc;
  logic        [7:0]  io_out_count;
  logic               io_out_overflow;

  always #5 clock = ~clock;

  mac_accumulator dut (
    .clock          (clock),
    .reset          (reset),
    .io_in_valid    (io_in_valid),
    .io_in_ready    (io_in_ready),
    .io_in_data     (io_in_data),
    .io_in_last     (io_in_last),
    .io_cfg_shift   (io_cfg_shift),
    .io_out_valid   (io_out_valid),
    .io_out_ready   (io_out_ready),
    .io_out_data    (io_out_data),
    .io_out_acc     (io_out_acc),
    .io_out_count   (io_out_count),
    .io_out_overflow(io_out_overflow)
  );

  typedef struct {
    longint acc;
    int     data;
    int     cnt;
    bit     ovf;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     failures = 0;
  longint m_acc = 0;
  int     m_cnt = 0;
  bit     m_ovf = 1'b0;
  bit     m_first = 1'b1;
  int     m_shift = 0;

  function automatic int requant(input longint a, input int sh);
    longint v;
    if (sh == 0) v = a;
    else v = (a + (64'sd1 << (sh - 1))) >>> sh;
    if (v > 127) v = 127;
    else if (v < -128) v = -128;
    return int'(v);
  endfunction

  task automatic model_beat(input int d, input bit last, input int sh);
    longint s;
    exp_t   e;
    if (m_first) begin
      m_acc = 0; m_cnt = 0; m_ovf = 1'b0; m_shift = sh;
    end
    s = m_acc + d;
    if (s > ACC_MAX) begin s = ACC_MAX; m_ovf = 1'b1; end
    else if (s < ACC_MIN) begin s = ACC_MIN; m_ovf = 1'b1; end
    m_acc = s;
    if (m_cnt < 255) m_cnt++;
    m_first = 1'b0;
    if (last) begin
      e.acc = m_acc; e.data = requant(m_acc, m_shift); e.cnt = m_cnt; e.ovf = m_ovf;
      sb.push_back(e);
      m_first = 1'b1;
    end
  endtask

  // Present one beat, wait (bounded) for ready, transfer on the next edge.
  task automatic send(input int d, input bit last, input int sh);
    int waited;
    waited = 0;
    io_in_valid = 1'b1; io_in_data = 16'(d); io_in_last = last; io_cfg_shift = 4'(sh);
    while (!io_in_ready && waited < 50) begin
      @(posedge clock); #1; waited++;
    end
    if (!io_in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", io_in_ready, waited);
      io_in_valid = 1'b0; io_in_last = 1'b0;
      return;
    end
    model_beat(d, last, sh);
    @(posedge clock); #1;
    io_in_valid = 1'b0; io_in_last = 1'b0;
  endtask

  task automatic sb_check(input string name);
    int   waited;
    exp_t e;
    waited = 0;
    while (!io_out_valid && waited < 50) begin
      @(posedge clock); #1; waited++;
    end
    checks++;
    if (io_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s out_valid timeout: got %0b, required 1", name, io_out_valid);
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected result: got acc=%0d, required none", name, io_out_acc);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (longint'(io_out_acc) !== e.acc) begin
      failures++; $display("FAIL %s acc: got %0d, required %0d", name, io_out_acc, e.acc);
    end
    checks++;
    if (int'(io_out_data) !== e.data) begin
      failures++; $display("FAIL %s data: got %0d, required %0d", name, io_out_data, e.data);
    end
    checks++;
    if (int'(io_out_count) !== e.cnt) begin
      failures++; $display("FAIL %s count: got %0d, required %0d", name, io_out_count, e.cnt);
    end
    checks++;
    if (io_out_overflow !== e.ovf) begin
      failures++; $display("FAIL %s ovf: got %0b, required %0b", name, io_out_overflow, e.ovf);
    end
    io_out_ready = 1'b1;
    @(posedge clock); #1;
    io_out_ready = 1'b0;
    checks++;
    if (io_out_valid !== 1'b0 || io_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s release: got valid=%0b ready=%0b, required valid=0 ready=1",
               name, io_out_valid, io_in_ready);
    end
  endtask

  task automatic test_reset();
    io_in_valid = 1'b0; io_in_data = '0; io_in_last = 1'b0; io_cfg_shift = '0;
    io_out_ready = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (io_out_valid !== 1'b0 || io_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_handshake: got valid=%0b ready=%0b, required valid=0 ready=1",
               io_out_valid, io_in_ready);
    end
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    checks++;
    if (io_out_acc !== 24'sd0 || io_out_data !== 8'sd0 || io_out_count !== 8'd0 ||
        io_out_overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got acc=%0d data=%0d cnt=%0d ovf=%0b, required all 0",
               io_out_acc, io_out_data, io_out_count, io_out_overflow);
    end
    m_first = 1'b1;
  endtask

  task automatic test_basic();
    send(100, 1'b0, 0);
    send(-20, 1'b0, 0);
    send(5, 1'b1, 0);
    checks++;
    if (io_out_valid !== 1'b1 || io_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_latency: got valid=%0b ready=%0b, required valid=1 ready=0",
               io_out_valid, io_in_ready);
    end
    sb_check("basic");
    send(1000, 1'b1, 4);
    sb_check("single_beat");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 300; i++) send(32767, i == 299, 0);
    checks++;
    if (io_out_overflow !== 1'b1 || io_out_count !== 8'd255) begin
      failures++;
      $display("FAIL overflow_flags: got ovf=%0b cnt=%0d, required ovf=1 cnt=255",
               io_out_overflow, io_out_count);
    end
    sb_check("overflow");
    send(1, 1'b1, 0);
    checks++;
    if (io_out_overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_cleared: got %0b, required 0", io_out_overflow);
    end
    sb_check("after_overflow");
  endtask

  task automatic test_negative();
    send(-32768, 1'b0, 8);
    send(-32768, 1'b1, 8);
    checks++;
    if (io_out_data !== -8'sd128) begin
      failures++; $display("FAIL negative_sat: got %0d, required -128", io_out_data);
    end
    sb_check("negative");
  endtask

  task automatic test_cfg_mid_group();
    send(1000, 1'b0, 4);
    send(500, 1'b1, 0);
    sb_check("cfg_mid_group");
  endtask

  task automatic test_backpressure();
    send(10, 1'b0, 2);
    send(20, 1'b1, 2);
    io_in_valid = 1'b1; io_in_data = 16'sd999; io_in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checks++;
      if (io_out_valid !== 1'b1 || io_in_ready !== 1'b0 ||
          longint'(io_out_acc) !== sb[0].acc || int'(io_out_data) !== sb[0].data ||
          int'(io_out_count) !== sb[0].cnt) begin
        failures++;
        $display("FAIL backpressure_hold: cycle %0d got valid=%0b ready=%0b acc=%0d data=%0d cnt=%0d, required 1 0 %0d %0d %0d",
                 i, io_out_valid, io_in_ready, io_out_acc, io_out_data, io_out_count,
                 sb[0].acc, sb[0].data, sb[0].cnt);
      end
    end
    io_in_valid = 1'b0; io_in_last = 1'b0;
    sb_check("backpressure");
    send(3, 1'b1, 0);
    sb_check("after_backpressure");
  endtask

  task automatic test_back_to_back();
    int len;
    int sh;
    for (int g = 0; g < 6; g++) begin
      len = int'($urandom_range(1, 5));
      sh  = int'($urandom_range(0, 15));
      for (int b = 0; b < len; b++)
        send(int'($urandom_range(0, 65535)) - 32768, b == len - 1, sh);
      sb_check("back_to_back");
    end
  endtask

  task automatic test_mid_reset();
    send(50, 1'b0, 0);
    send(60, 1'b0, 0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (io_out_valid !== 1'b0 || io_in_ready !== 1'b1 || io_out_acc !== 24'sd0) begin
      failures++;
      $display("FAIL mid_reset: got valid=%0b ready=%0b acc=%0d, required 0 1 0",
               io_out_valid, io_in_ready, io_out_acc);
    end
    m_first = 1'b1;
    #2 reset = 1'b0;
    @(posedge clock); #1;
    send(7, 1'b1, 0);
    sb_check("after_mid_reset");
    send(9, 1'b1, 0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (io_out_valid !== 1'b0 || io_out_acc !== 24'sd0) begin
      failures++;
      $display("FAIL hold_reset: got valid=%0b acc=%0d, required 0 0", io_out_valid, io_out_acc);
    end
    if (sb.size() > 0) void'(sb.pop_back());
    m_first = 1'b1;
    #2 reset = 1'b0;
    @(posedge clock); #1;
    send(-4, 1'b1, 3);
    sb_check("after_hold_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_negative();
    test_cfg_mid_group();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL scoreboard_left: got %0d pending, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
